sram_sync_param: RTL and testbench
==================================

SRAM_SYNC_PARAM -- requirements
Module: sram_sync_param

Interface
REQ-001 Parameter DATA_W, default 8, word width in bits (1..64).
REQ-002 Parameter ADDR_W, default 6, address width; DEPTH = 2**ADDR_W words.
REQ-003 Parameter INIT_CLR, default 1; when 1, every word is zeroed after reset; when 0, no clearing is done.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 adr  input  ADDR_W  word address for read or write.
REQ-007 rd  input  1  read request, sampled at the clock edge.
REQ-008 wr  input  1  write request, sampled at the clock edge.
REQ-009 d  input  DATA_W  write data.
REQ-010 q  output  DATA_W  registered read data.
REQ-011 qv  output  1  read-valid; high for one cycle per accepted read.
REQ-012 busy  output  1  high while the clear sweep runs; rd and wr are ignored while it is high.
REQ-013 coll  output  1  one-cycle pulse when rd and wr are both high in an accepted cycle.

Function
REQ-014 The FSM SHALL have two states: CLEAR and IDLE.
- On reset it enters CLEAR if INIT_CLR=1, otherwise IDLE.
REQ-015 In CLEAR, an internal pointer SHALL start at 0 and write zero to one word per cycle, incrementing each cycle.
- After writing word DEPTH-1, the next state is IDLE.
- The sweep lasts exactly DEPTH cycles.
REQ-016 busy SHALL equal (state==CLEAR), driven from a register with no combinational path from inputs.
REQ-017 In CLEAR, rd and wr SHALL have no effect: no memory write from d, qv=0, coll=0.
REQ-018 In IDLE with rd=1: q SHALL take mem[adr] at the same edge, so q and qv are valid in the cycle after the request (latency 1), with qv=1.
REQ-019 In IDLE with wr=1 and rd=0: mem[adr] SHALL take d at the edge, and qv=0 in the following cycle.
REQ-020 In IDLE with rd=1 and wr=1: the read SHALL be performed and the write discarded (read priority), with coll=1 in the following cycle.
REQ-021 When neither rd nor wr is high, or the FSM is in CLEAR:
- q SHALL hold its last value (no tri-state);
- qv and coll SHALL be 0.
REQ-022 A read of an address in the cycle after a write to it SHALL return the newly written data.
REQ-023 Back-to-back reads SHALL be accepted every cycle, with qv held high for each consecutive read.
REQ-024 The address SHALL be used unmodified; every ADDR_W value is valid, with no wrap logic or range check.
REQ-025 Memory contents SHALL be preserved across reset when INIT_CLR=0.

Reset
REQ-026 While rst=1, the outputs SHALL be forced at the next edge to: q=0, qv=0, coll=0, busy=INIT_CLR; the clear pointer is set to 0.
REQ-027 Reset asserted during CLEAR SHALL restart the sweep from word 0, giving a full DEPTH cycles of busy after rst falls.
REQ-028 Reset asserted while a read is outstanding SHALL suppress that read's qv.
REQ-029 Reset asserted in the same cycle as wr SHALL discard the write.

Verification (DATA_W=8, ADDR_W=6, INIT_CLR=1)
REQ-030 Release rst, count busy cycles, then read adr 63.
- busy SHALL be high for exactly 64 cycles.
- The read SHALL return q=0x00 with qv=1.
REQ-031 Write d=0xBE to adr 10, then read adr 10 on the next cycle.
- The cycle after the read SHALL show q=0xBE and qv=1.
REQ-032 Preload adr 5 with 0x11, then assert rd=1 and wr=1 together with adr=5 and d=0xAA.
- The response SHALL be q=0x11, qv=1, coll=1.
- A later read of adr 5 SHALL still return 0x11.
REQ-033 Assert rd at adr 3 during cycle 10 of the sweep.
- qv SHALL stay 0.
- After busy falls, reading adr 3 SHALL return 0x00.
REQ-034 Pulse rst at sweep cycle 20.
- busy SHALL remain high for 64 further cycles after rst falls.
REQ-035 Write 0x01, 0x02, 0x03 to adr 0..2, then read adr 0,1,2 on consecutive cycles.
- q SHALL be 0x01, 0x02, 0x03 on consecutive cycles, with qv high for 3 cycles, then low.

Source files
------------

// File: rtl/sram_sync_param.sv
// Single-port synchronous SRAM with registered read data, read-priority
// collision handling and an optional post-reset zeroing sweep.
module sram_sync_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 6,
  parameter int INIT_CLR = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] adr,
  input  logic              rd,
  input  logic              wr,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q,
  output logic              qv,
  output logic              busy,
  output logic              coll
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  localparam state_t RESET_STATE = (INIT_CLR != 0) ? CLEAR : IDLE;

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] next_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  // State and clear pointer; reset restarts the sweep from word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RESET_STATE;
      ptr   <= '0;
    end else begin
      state <= next_state;
      ptr   <= next_ptr;
    end
  end

  // Sweep advances one word per cycle and leaves CLEAR after the last word.
  always_comb begin
    next_state = state;
    next_ptr   = ptr;
    case (state)
      CLEAR: begin
        next_ptr = ptr + 1'b1;
        if (ptr == '1) begin
          next_state = IDLE;
        end
      end
      IDLE:    next_state = IDLE;
      default: next_state = RESET_STATE;
    endcase
  end

  // Memory array: zeroing during the sweep, otherwise writes that do not collide with a read.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[ptr] <= '0;
      end else if (wr && !rd) begin
        mem[adr] <= d;
      end
    end
  end

  // Registered read port with one-cycle valid and collision pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= '0;
      qv   <= 1'b0;
      coll <= 1'b0;
    end else begin
      qv   <= 1'b0;
      coll <= 1'b0;
      if (state == IDLE && rd) begin
        q    <= mem[adr];
        qv   <= 1'b1;
        coll <= wr;
      end
    end
  end

  // busy decodes the state register only, so it has no path from inputs.
  assign busy = (state == CLEAR);

endmodule

// File: tb/tb_sram_sync_param.sv
// Self-checking bench for sram_sync_param (DATA_W=8, ADDR_W=6, INIT_CLR=1):
// directed scenarios plus randomized traffic against a behavioural model.
module tb_sram_sync_param;

  logic       clk;
  logic       rst;
  logic [5:0] adr;
  logic       rd;
  logic       wr;
  logic [7:0] d;
  logic [7:0] q;
  logic       qv;
  logic       busy;
  logic       coll;

  int unsigned n_cmp;
  int unsigned n_err;

  // Behavioural reference: contents, remaining sweep cycles, expected outputs.
  logic [7:0]  ref_mem [64];
  int unsigned clear_left;
  logic [7:0]  exp_q;
  logic        exp_qv;
  logic        exp_coll;

  sram_sync_param #(
    .DATA_W  (8),
    .ADDR_W  (6),
    .INIT_CLR(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .adr (adr),
    .rd  (rd),
    .wr  (wr),
    .d   (d),
    .q   (q),
    .qv  (qv),
    .busy(busy),
    .coll(coll)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model across the edge, compare outputs.
  task automatic tick(input logic r, input logic rdi, input logic wri,
                      input logic [5:0] a, input logic [7:0] dd);
    rst = r;
    rd  = rdi;
    wr  = wri;
    adr = a;
    d   = dd;
    @(posedge clk);
    if (r) begin
      exp_q      = 8'h00;
      exp_qv     = 1'b0;
      exp_coll   = 1'b0;
      clear_left = 64;
      // By the time any access is accepted the sweep has zeroed everything.
      for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
    end else if (clear_left > 0) begin
      clear_left--;
      exp_qv   = 1'b0;
      exp_coll = 1'b0;
    end else if (rdi) begin
      exp_q    = ref_mem[a];
      exp_qv   = 1'b1;
      exp_coll = wri;
    end else begin
      exp_qv   = 1'b0;
      exp_coll = 1'b0;
      if (wri) ref_mem[a] = dd;
    end
    #1;
    check_val("q", 64'(q), 64'(exp_q));
    check_val("qv", 64'(qv), 64'(exp_qv));
    check_val("coll", 64'(coll), 64'(exp_coll));
    check_val("busy", 64'(busy), 64'(clear_left > 0));
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 1'b0, 6'd0, 8'h00);
  endtask

  // Reset for one edge, then count how many sampled cycles busy stays high.
  task automatic reset_and_count(input string tag);
    int unsigned n;
    int unsigned guard;
    tick(1'b1, 1'b0, 1'b0, 6'd0, 8'h00);
    n = busy ? 1 : 0;
    guard = 0;
    while (busy && guard < 200) begin
      idle();
      guard++;
      if (busy) n++;
    end
    check_val(tag, 64'(n), 64'd64);
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    clear_left = 0;
    exp_q      = 8'h00;
    exp_qv     = 1'b0;
    exp_coll   = 1'b0;
    rst = 1'b1; rd = 1'b0; wr = 1'b0; adr = '0; d = '0;

    // Reset values and sweep length, then read the last word.
    reset_and_count("busy_len_initial");
    tick(1'b0, 1'b1, 1'b0, 6'd63, 8'h00);
    check_val("rd63_q", 64'(q), 64'h00);
    check_val("rd63_qv", 64'(qv), 64'd1);
    idle();

    // Write followed immediately by a read of the same word.
    tick(1'b0, 1'b0, 1'b1, 6'd10, 8'hBE);
    check_val("wr_qv", 64'(qv), 64'd0);
    tick(1'b0, 1'b1, 1'b0, 6'd10, 8'h00);
    check_val("raw_q", 64'(q), 64'hBE);
    idle();

    // Collision: read wins, write discarded.
    tick(1'b0, 1'b0, 1'b1, 6'd5, 8'h11);
    tick(1'b0, 1'b1, 1'b1, 6'd5, 8'hAA);
    check_val("coll_q", 64'(q), 64'h11);
    check_val("coll_pulse", 64'(coll), 64'd1);
    idle();
    check_val("coll_drop", 64'(coll), 64'd0);
    tick(1'b0, 1'b1, 1'b0, 6'd5, 8'h00);
    check_val("coll_keep", 64'(q), 64'h11);

    // Read during the sweep is ignored; sweep zeroes a previously written word.
    tick(1'b0, 1'b0, 1'b1, 6'd3, 8'h77);
    tick(1'b1, 1'b0, 1'b0, 6'd0, 8'h00);
    for (int i = 0; i < 9; i++) idle();
    tick(1'b0, 1'b1, 1'b0, 6'd3, 8'h00);
    check_val("sweep_rd_qv", 64'(qv), 64'd0);
    for (int i = 0; i < 100 && busy; i++) idle();
    check_val("sweep_done", 64'(busy), 64'd0);
    tick(1'b0, 1'b1, 1'b0, 6'd3, 8'h00);
    check_val("rd3_zero", 64'(q), 64'h00);

    // Reset mid-sweep restarts a full-length sweep.
    tick(1'b1, 1'b0, 1'b0, 6'd0, 8'h00);
    for (int i = 0; i < 19; i++) idle();
    reset_and_count("busy_len_restart");

    // Consecutive reads stream with qv held high, then drop.
    tick(1'b0, 1'b0, 1'b1, 6'd0, 8'h01);
    tick(1'b0, 1'b0, 1'b1, 6'd1, 8'h02);
    tick(1'b0, 1'b0, 1'b1, 6'd2, 8'h03);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 1'b0, 6'(i), 8'h00);
      check_val("burst_q", 64'(q), 64'(i + 1));
      check_val("burst_qv", 64'(qv), 64'd1);
    end
    idle();
    check_val("burst_end_qv", 64'(qv), 64'd0);

    // Randomized traffic with occasional resets, focused on a few addresses.
    for (int i = 0; i < 3000; i++) begin
      logic       r;
      logic [5:0] a;
      r = ($urandom_range(0, 299) == 0);
      a = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7));
      tick(r, 1'($urandom), 1'($urandom), a, 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Safety net against a hung simulation.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
